// File: rtl/cube_scan_driver.sv
// 8x8x8 LED cube scan driver: shifts one z-layer of the captured generation into
// eight 74HC595 chains, then blanks, latches and lights that layer.
module cube_scan_driver #(
  parameter int CLK_DIV      = 4,
  parameter int BLANK_CYCLES = 16,
  parameter int LAYER_HOLD   = 2000
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [511:0] Cells,
  input  logic         Frame_valid,
  output logic [7:0]   Layer,
  output logic [7:0]   Ser_data,
  output logic         Sr_clk,
  output logic         Sr_latch,
  output logic         Sr_oe_n,
  output logic         Frame_done
);

  localparam int DIV_W   = (CLK_DIV > 1)      ? $clog2(CLK_DIV)      : 1;
  localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int HOLD_W  = (LAYER_HOLD > 1)   ? $clog2(LAYER_HOLD)   : 1;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_BLANK = 3'd2,
    ST_LATCH = 3'd3,
    ST_SHOW  = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [2:0]           x_r, x_s;
  logic [DIV_W-1:0]     div_r, div_s;
  logic                 half_r, half_s;
  logic [BLANK_W-1:0]   blank_r, blank_s;
  logic [HOLD_W-1:0]    hold_r, hold_s;
  logic [2:0]           z_r, z_s;
  logic [511:0]         buf_r, buf_s;
  logic                 pending_r, pending_s;
  logic                 first_r, first_s;

  logic [7:0]           layer_r, layer_s;
  logic [7:0]           ser_r, ser_s;
  logic                 sr_clk_r, sr_clk_s;
  logic                 latch_r, latch_s;
  logic                 oe_n_r, oe_n_s;
  logic                 done_r, done_s;

  assign Layer      = layer_r;
  assign Ser_data   = ser_r;
  assign Sr_clk     = sr_clk_r;
  assign Sr_latch   = latch_r;
  assign Sr_oe_n    = oe_n_r;
  assign Frame_done = done_r;

  // Next state, counters and frame buffer; outputs are derived from the next state
  // so that every registered output lines up with the state it belongs to.
  always_comb begin
    state_s   = state_r;
    x_s       = x_r;
    div_s     = div_r;
    half_s    = half_r;
    blank_s   = blank_r;
    hold_s    = hold_r;
    z_s       = z_r;
    buf_s     = buf_r;
    pending_s = pending_r | Frame_valid;
    first_s   = first_r;

    case (state_r)
      ST_LOAD: begin
        if ((z_r == 3'd0) && (pending_r || first_r || Frame_valid)) begin
          buf_s     = Cells;
          pending_s = 1'b0;
          first_s   = 1'b0;
        end else begin
          buf_s = buf_r;
        end
        state_s = ST_SHIFT;
        x_s     = 3'd7;
        div_s   = {DIV_W{1'b0}};
        half_s  = 1'b0;
      end
      ST_SHIFT: begin
        if (div_r == DIV_W'(CLK_DIV - 1)) begin
          div_s = {DIV_W{1'b0}};
          if (half_r) begin
            half_s = 1'b0;
            if (x_r == 3'd0) begin
              state_s = ST_BLANK;
              blank_s = {BLANK_W{1'b0}};
            end else begin
              x_s = x_r - 3'd1;
            end
          end else begin
            half_s = 1'b1;
          end
        end else begin
          div_s = div_r + DIV_W'(1);
        end
      end
      ST_BLANK: begin
        if (blank_r == BLANK_W'(BLANK_CYCLES - 1)) begin
          state_s = ST_LATCH;
        end else begin
          blank_s = blank_r + BLANK_W'(1);
        end
      end
      ST_LATCH: begin
        state_s = ST_SHOW;
        hold_s  = {HOLD_W{1'b0}};
      end
      ST_SHOW: begin
        if (hold_r == HOLD_W'(LAYER_HOLD - 1)) begin
          state_s = ST_LOAD;
          z_s     = z_r + 3'd1;
        end else begin
          hold_s = hold_r + HOLD_W'(1);
        end
      end
      default: begin
        state_s = ST_LOAD;
      end
    endcase

    layer_s  = layer_r;
    oe_n_s   = oe_n_r;
    ser_s    = ser_r;
    sr_clk_s = 1'b0;
    latch_s  = 1'b0;
    done_s   = 1'b0;

    // LOAD and SHIFT leave Layer/Sr_oe_n alone so the previous layer stays lit.
    case (state_s)
      ST_LOAD: begin
        layer_s = layer_r;
      end
      ST_SHIFT: begin
        sr_clk_s = half_s;
        for (int y = 0; y < 8; y++) begin
          ser_s[y] = buf_s[{z_s, 3'(y), x_s}];
        end
      end
      ST_BLANK: begin
        layer_s = 8'h00;
        oe_n_s  = 1'b1;
      end
      ST_LATCH: begin
        latch_s = 1'b1;
        layer_s = 8'h00;
        oe_n_s  = 1'b1;
      end
      ST_SHOW: begin
        layer_s = 8'd1 << z_s;
        oe_n_s  = 1'b0;
        done_s  = (z_s == 3'd7) && (hold_s == HOLD_W'(LAYER_HOLD - 1));
      end
      default: begin
        layer_s = 8'h00;
        oe_n_s  = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r   <= ST_LOAD;
      x_r       <= 3'd7;
      div_r     <= {DIV_W{1'b0}};
      half_r    <= 1'b0;
      blank_r   <= {BLANK_W{1'b0}};
      hold_r    <= {HOLD_W{1'b0}};
      z_r       <= 3'd0;
      buf_r     <= {512{1'b0}};
      pending_r <= 1'b0;
      first_r   <= 1'b1;
      layer_r   <= 8'h00;
      ser_r     <= 8'h00;
      sr_clk_r  <= 1'b0;
      latch_r   <= 1'b0;
      oe_n_r    <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      x_r       <= x_s;
      div_r     <= div_s;
      half_r    <= half_s;
      blank_r   <= blank_s;
      hold_r    <= hold_s;
      z_r       <= z_s;
      buf_r     <= buf_s;
      pending_r <= pending_s;
      first_r   <= first_s;
      layer_r   <= layer_s;
      ser_r     <= ser_s;
      sr_clk_r  <= sr_clk_s;
      latch_r   <= latch_s;
      oe_n_r    <= oe_n_s;
      done_r    <= done_s;
    end
  end

endmodule
